// File: rtl/rat_pkg.sv
// Shared types and encodings for the extended RAT control unit.
package rat_pkg;

    localparam int unsigned OP_W       = 7;
    localparam int unsigned ALU_CODE_W = 4;
    localparam int unsigned CNT_W      = 3;

    typedef enum logic [2:0] {ST_INIT, ST_FETCH, ST_EXEC, ST_WAIT, ST_INTR} state_t;
    typedef enum logic [1:0] {CLS_SIMPLE, CLS_READ, CLS_ILLEGAL} iclass_t;

    // Register-format opcodes {hi5, lo2}
    localparam logic [OP_W-1:0] OP_AND   = 7'b0000000, OP_OR    = 7'b0000001;
    localparam logic [OP_W-1:0] OP_EXOR  = 7'b0000010, OP_TEST  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_ADD   = 7'b0000100, OP_ADDC  = 7'b0000101;
    localparam logic [OP_W-1:0] OP_SUB   = 7'b0000110, OP_SUBC  = 7'b0000111;
    localparam logic [OP_W-1:0] OP_CMP   = 7'b0001000, OP_MOV   = 7'b0001001;
    localparam logic [OP_W-1:0] OP_LD    = 7'b0001010, OP_ST    = 7'b0001011;
    localparam logic [OP_W-1:0] OP_BRN   = 7'b0010000, OP_CALL  = 7'b0010001;
    localparam logic [OP_W-1:0] OP_BREQ  = 7'b0010010, OP_BRNE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRCS  = 7'b0010100, OP_BRCC  = 7'b0010101;
    localparam logic [OP_W-1:0] OP_LSL   = 7'b0100000, OP_LSR   = 7'b0100001;
    localparam logic [OP_W-1:0] OP_ROL   = 7'b0100010, OP_ROR   = 7'b0100011;
    localparam logic [OP_W-1:0] OP_ASR   = 7'b0100100, OP_PUSH  = 7'b0100101;
    localparam logic [OP_W-1:0] OP_POP   = 7'b0100110, OP_WSP   = 7'b0101000;
    localparam logic [OP_W-1:0] OP_CLC   = 7'b0110000, OP_SEC   = 7'b0110001;
    localparam logic [OP_W-1:0] OP_RET   = 7'b0110010, OP_SEI   = 7'b0110100;
    localparam logic [OP_W-1:0] OP_CLI   = 7'b0110101, OP_RETID = 7'b0110110;
    localparam logic [OP_W-1:0] OP_RETIE = 7'b0110111;

    // Immediate-format opcodes: only hi5 matters, compare after masking lo2
    localparam logic [OP_W-1:0] OP_IMM_MASK = 7'b1111100;
    localparam logic [OP_W-1:0] OP_AND_I  = 7'b1000000, OP_OR_I   = 7'b1000100;
    localparam logic [OP_W-1:0] OP_EXOR_I = 7'b1001000, OP_TEST_I = 7'b1001100;
    localparam logic [OP_W-1:0] OP_ADD_I  = 7'b1010000, OP_ADDC_I = 7'b1010100;
    localparam logic [OP_W-1:0] OP_SUB_I  = 7'b1011000, OP_SUBC_I = 7'b1011100;
    localparam logic [OP_W-1:0] OP_CMP_I  = 7'b1100000, OP_IN_I   = 7'b1100100;
    localparam logic [OP_W-1:0] OP_OUT_I  = 7'b1101000, OP_MOV_I  = 7'b1101100;
    localparam logic [OP_W-1:0] OP_LD_I   = 7'b1110000, OP_ST_I   = 7'b1110100;

    localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 4'd0,  ALU_ADDC = 4'd1,  ALU_SUB  = 4'd2;
    localparam logic [ALU_CODE_W-1:0] ALU_SUBC = 4'd3,  ALU_CMP  = 4'd4,  ALU_AND  = 4'd5;
    localparam logic [ALU_CODE_W-1:0] ALU_OR   = 4'd6,  ALU_EXOR = 4'd7,  ALU_TEST = 4'd8;
    localparam logic [ALU_CODE_W-1:0] ALU_LSL  = 4'd9,  ALU_LSR  = 4'd10, ALU_ROL  = 4'd11;
    localparam logic [ALU_CODE_W-1:0] ALU_ROR  = 4'd12, ALU_ASR  = 4'd13, ALU_MOV  = 4'd14;

    localparam logic [1:0] PC_MUX_IMM = 2'd0, PC_MUX_SCR = 2'd1, PC_MUX_INTR = 2'd2;
    localparam logic [1:0] RF_SEL_ALU = 2'd0, RF_SEL_SCR = 2'd1, RF_SEL_SP = 2'd2, RF_SEL_IN = 2'd3;
    localparam logic [1:0] SCR_ADR_Y  = 2'd0, SCR_ADR_IMM = 2'd1, SCR_ADR_SP = 2'd2, SCR_ADR_SPM1 = 2'd3;
    localparam logic       SCR_DAT_X  = 1'b0, SCR_DAT_PC = 1'b1;

    typedef struct packed {
        logic                  i_set;
        logic                  i_clr;
        logic                  pc_ld;
        logic                  pc_inc;
        logic [1:0]            pc_mux_sel;
        logic                  alu_opy_sel;
        logic [ALU_CODE_W-1:0] alu_sel;
        logic                  rf_wr;
        logic [1:0]            rf_wr_sel;
        logic                  sp_ld;
        logic                  sp_incr;
        logic                  sp_decr;
        logic                  scr_we;
        logic [1:0]            scr_addr_sel;
        logic                  scr_data_sel;
        logic                  flg_c_set;
        logic                  flg_c_clr;
        logic                  flg_c_ld;
        logic                  flg_z_ld;
        logic                  flg_ld_sel;
        logic                  flg_shad_ld;
        logic                  rst;
        logic                  io_strb;
        logic                  illegal;
    } ctrl_t;

endpackage

// File: rtl/rat_decode.sv
// Combinational opcode decoder: instruction class plus the controls an
// instruction asserts in its final (commit) cycle.
module rat_decode
    import rat_pkg::*;
(
    input  logic [4:0] opcode_hi_5,
    input  logic [1:0] opcode_lo_2,
    input  logic       c,
    input  logic       z,
    output iclass_t    iclass,
    output ctrl_t      ctl
);

    logic [OP_W-1:0]       op;
    logic                  alu_en;
    logic [ALU_CODE_W-1:0] alu_code;

    assign op = {opcode_hi_5, opcode_lo_2};

    always_comb begin
        ctl      = '0;
        iclass   = CLS_SIMPLE;
        alu_en   = 1'b0;
        alu_code = ALU_ADD;
        if (op[6]) begin
            case (op & OP_IMM_MASK)
                OP_AND_I:  begin alu_en = 1'b1; alu_code = ALU_AND;  end
                OP_OR_I:   begin alu_en = 1'b1; alu_code = ALU_OR;   end
                OP_EXOR_I: begin alu_en = 1'b1; alu_code = ALU_EXOR; end
                OP_TEST_I: begin alu_en = 1'b1; alu_code = ALU_TEST; end
                OP_ADD_I:  begin alu_en = 1'b1; alu_code = ALU_ADD;  end
                OP_ADDC_I: begin alu_en = 1'b1; alu_code = ALU_ADDC; end
                OP_SUB_I:  begin alu_en = 1'b1; alu_code = ALU_SUB;  end
                OP_SUBC_I: begin alu_en = 1'b1; alu_code = ALU_SUBC; end
                OP_CMP_I:  begin alu_en = 1'b1; alu_code = ALU_CMP;  end
                OP_MOV_I:  begin alu_en = 1'b1; alu_code = ALU_MOV;  end
                OP_IN_I:   begin ctl.rf_wr = 1'b1; ctl.rf_wr_sel = RF_SEL_IN; end
                OP_OUT_I:  ctl.io_strb = 1'b1;
                OP_LD_I:   begin
                    iclass = CLS_READ; ctl.scr_addr_sel = SCR_ADR_IMM;
                    ctl.rf_wr = 1'b1; ctl.rf_wr_sel = RF_SEL_SCR;
                end
                OP_ST_I:   begin ctl.scr_we = 1'b1; ctl.scr_addr_sel = SCR_ADR_IMM; end
                default:   iclass = CLS_ILLEGAL;
            endcase
        end else begin
            case (op)
                OP_AND:  begin alu_en = 1'b1; alu_code = ALU_AND;  end
                OP_OR:   begin alu_en = 1'b1; alu_code = ALU_OR;   end
                OP_EXOR: begin alu_en = 1'b1; alu_code = ALU_EXOR; end
                OP_TEST: begin alu_en = 1'b1; alu_code = ALU_TEST; end
                OP_ADD:  begin alu_en = 1'b1; alu_code = ALU_ADD;  end
                OP_ADDC: begin alu_en = 1'b1; alu_code = ALU_ADDC; end
                OP_SUB:  begin alu_en = 1'b1; alu_code = ALU_SUB;  end
                OP_SUBC: begin alu_en = 1'b1; alu_code = ALU_SUBC; end
                OP_CMP:  begin alu_en = 1'b1; alu_code = ALU_CMP;  end
                OP_MOV:  begin alu_en = 1'b1; alu_code = ALU_MOV;  end
                OP_LSL:  begin alu_en = 1'b1; alu_code = ALU_LSL;  end
                OP_LSR:  begin alu_en = 1'b1; alu_code = ALU_LSR;  end
                OP_ROL:  begin alu_en = 1'b1; alu_code = ALU_ROL;  end
                OP_ROR:  begin alu_en = 1'b1; alu_code = ALU_ROR;  end
                OP_ASR:  begin alu_en = 1'b1; alu_code = ALU_ASR;  end
                OP_LD:   begin
                    iclass = CLS_READ; ctl.scr_addr_sel = SCR_ADR_Y;
                    ctl.rf_wr = 1'b1; ctl.rf_wr_sel = RF_SEL_SCR;
                end
                OP_ST:   begin ctl.scr_we = 1'b1; ctl.scr_addr_sel = SCR_ADR_Y; end
                OP_BRN:  ctl.pc_ld = 1'b1;
                OP_BREQ: ctl.pc_ld = z;
                OP_BRNE: ctl.pc_ld = ~z;
                OP_BRCS: ctl.pc_ld = c;
                OP_BRCC: ctl.pc_ld = ~c;
                OP_CALL: begin
                    ctl.pc_ld = 1'b1; ctl.sp_decr = 1'b1; ctl.scr_we = 1'b1;
                    ctl.scr_data_sel = SCR_DAT_PC; ctl.scr_addr_sel = SCR_ADR_SPM1;
                end
                OP_PUSH: begin
                    ctl.sp_decr = 1'b1; ctl.scr_we = 1'b1;
                    ctl.scr_data_sel = SCR_DAT_X; ctl.scr_addr_sel = SCR_ADR_SPM1;
                end
                OP_POP:  begin
                    iclass = CLS_READ; ctl.scr_addr_sel = SCR_ADR_SP; ctl.sp_incr = 1'b1;
                    ctl.rf_wr = 1'b1; ctl.rf_wr_sel = RF_SEL_SCR;
                end
                OP_RET, OP_RETID, OP_RETIE: begin
                    iclass = CLS_READ; ctl.scr_addr_sel = SCR_ADR_SP; ctl.sp_incr = 1'b1;
                    ctl.pc_ld = 1'b1; ctl.pc_mux_sel = PC_MUX_SCR;
                    // Interrupt returns restore C/Z from the shadow copy
                    if (op != OP_RET) begin
                        ctl.flg_ld_sel = 1'b1; ctl.flg_c_ld = 1'b1; ctl.flg_z_ld = 1'b1;
                        ctl.i_set = (op == OP_RETIE);
                        ctl.i_clr = (op == OP_RETID);
                    end
                end
                OP_WSP:  ctl.sp_ld = 1'b1;
                OP_CLC:  ctl.flg_c_clr = 1'b1;
                OP_SEC:  ctl.flg_c_set = 1'b1;
                OP_SEI:  ctl.i_set = 1'b1;
                OP_CLI:  ctl.i_clr = 1'b1;
                default: iclass = CLS_ILLEGAL;
            endcase
        end

        // Shared ALU write-back and flag policy
        if (alu_en) begin
            ctl.alu_sel     = alu_code;
            ctl.alu_opy_sel = op[6];
            case (alu_code)
                ALU_AND, ALU_OR, ALU_EXOR: begin
                    ctl.rf_wr = 1'b1; ctl.flg_c_clr = 1'b1; ctl.flg_z_ld = 1'b1;
                end
                ALU_TEST: begin ctl.flg_c_clr = 1'b1; ctl.flg_z_ld = 1'b1; end
                ALU_CMP:  begin ctl.flg_c_ld = 1'b1; ctl.flg_z_ld = 1'b1; end
                ALU_MOV:  ctl.rf_wr = 1'b1;
                default: begin
                    ctl.rf_wr = 1'b1; ctl.flg_c_ld = 1'b1; ctl.flg_z_ld = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/rat_control_unit_ext.sv
// Extended RAT MCU control FSM: fetch/exec, scratch-read wait states,
// interrupt entry and illegal-opcode handling.
module rat_control_unit_ext
    import rat_pkg::*;
#(
    parameter int unsigned SCR_WAIT    = 0,
    parameter bit          ILLEGAL_RST = 1'b1,
    parameter int unsigned ALU_SEL_W   = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 C,
    input  logic                 Z,
    input  logic                 INT,
    input  logic [4:0]           OPCODE_HI_5,
    input  logic [1:0]           OPCODE_LO_2,
    output logic                 I_SET,
    output logic                 I_CLR,
    output logic                 PC_LD,
    output logic                 PC_INC,
    output logic [1:0]           PC_MUX_SEL,
    output logic                 ALU_OPY_SEL,
    output logic [ALU_SEL_W-1:0] ALU_SEL,
    output logic                 RF_WR,
    output logic [1:0]           RF_WR_SEL,
    output logic                 SP_LD,
    output logic                 SP_INCR,
    output logic                 SP_DECR,
    output logic                 SCR_WE,
    output logic [1:0]           SCR_ADDR_SEL,
    output logic                 SCR_DATA_SEL,
    output logic                 FLG_C_SET,
    output logic                 FLG_C_CLR,
    output logic                 FLG_C_LD,
    output logic                 FLG_Z_LD,
    output logic                 FLG_LD_SEL,
    output logic                 FLG_SHAD_LD,
    output logic                 RST,
    output logic                 IO_STRB,
    output logic                 ILLEGAL
);

    state_t            st_q, st_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    iclass_t           iclass;
    ctrl_t             dec_ctl, ctl;
    logic              last;

    rat_decode u_decode (
        .opcode_hi_5 (OPCODE_HI_5),
        .opcode_lo_2 (OPCODE_LO_2),
        .c           (C),
        .z           (Z),
        .iclass      (iclass),
        .ctl         (dec_ctl)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            st_q  <= ST_INIT;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        ctl   = '0;
        last  = 1'b0;
        case (st_q)
            ST_INIT: begin
                ctl.rst = 1'b1;
                st_d    = ST_FETCH;
            end
            ST_FETCH: begin
                ctl.pc_inc = 1'b1;
                st_d       = ST_EXEC;
            end
            ST_EXEC: begin
                if (iclass == CLS_ILLEGAL) begin
                    ctl.illegal = 1'b1;
                    ctl.rst     = ILLEGAL_RST;
                    last        = 1'b1;
                end else if (iclass == CLS_READ && SCR_WAIT != 0) begin
                    ctl.scr_addr_sel = dec_ctl.scr_addr_sel;
                    cnt_d            = CNT_W'(SCR_WAIT);
                    st_d             = ST_WAIT;
                end else begin
                    ctl  = dec_ctl;
                    last = 1'b1;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Address stays put; commit only when the data is valid
                if (cnt_q == CNT_W'(1)) begin
                    ctl  = dec_ctl;
                    last = 1'b1;
                end else begin
                    ctl.scr_addr_sel = dec_ctl.scr_addr_sel;
                end
            end
            ST_INTR: begin
                ctl.pc_ld        = 1'b1;
                ctl.pc_mux_sel   = PC_MUX_INTR;
                ctl.sp_decr      = 1'b1;
                ctl.scr_we       = 1'b1;
                ctl.scr_data_sel = SCR_DAT_PC;
                ctl.scr_addr_sel = SCR_ADR_SPM1;
                ctl.flg_shad_ld  = 1'b1;
                ctl.i_clr        = 1'b1;
                st_d             = ST_FETCH;
            end
            default: st_d = ST_INIT;
        endcase

        if (last) begin
            st_d = INT ? ST_INTR : ST_FETCH;
        end
        // A reset cycle never writes, pushes or touches flags
        if (RESET) begin
            ctl = '0;
        end
    end

    assign I_SET        = ctl.i_set;
    assign I_CLR        = ctl.i_clr;
    assign PC_LD        = ctl.pc_ld;
    assign PC_INC       = ctl.pc_inc;
    assign PC_MUX_SEL   = ctl.pc_mux_sel;
    assign ALU_OPY_SEL  = ctl.alu_opy_sel;
    assign ALU_SEL      = ALU_SEL_W'(ctl.alu_sel);
    assign RF_WR        = ctl.rf_wr;
    assign RF_WR_SEL    = ctl.rf_wr_sel;
    assign SP_LD        = ctl.sp_ld;
    assign SP_INCR      = ctl.sp_incr;
    assign SP_DECR      = ctl.sp_decr;
    assign SCR_WE       = ctl.scr_we;
    assign SCR_ADDR_SEL = ctl.scr_addr_sel;
    assign SCR_DATA_SEL = ctl.scr_data_sel;
    assign FLG_C_SET    = ctl.flg_c_set;
    assign FLG_C_CLR    = ctl.flg_c_clr;
    assign FLG_C_LD     = ctl.flg_c_ld;
    assign FLG_Z_LD     = ctl.flg_z_ld;
    assign FLG_LD_SEL   = ctl.flg_ld_sel;
    assign FLG_SHAD_LD  = ctl.flg_shad_ld;
    assign RST          = ctl.rst;
    assign IO_STRB      = ctl.io_strb;
    assign ILLEGAL      = ctl.illegal;

endmodule
